// File: rtl/wam_pkg.sv
// Shared constants and helpers for the whack-a-mole key matrix scanner.
// Holds matrix geometry, row drive encodings and the priority helper.
package wam_pkg;

  localparam int NUM_ROWS   = 3;
  localparam int NUM_COLS   = 3;
  localparam int NUM_KEYS   = 9;
  localparam int KEY_CODE_W = 4;

  localparam int ROW_SETTLE_CYCLES_DEF = 50_000;
  localparam int DEBOUNCE_SCANS_DEF    = 4;

  localparam logic [2:0] ROW0_ACTIVE = 3'b110;
  localparam logic [2:0] ROW1_ACTIVE = 3'b101;
  localparam logic [2:0] ROW2_ACTIVE = 3'b011;

  typedef logic [KEY_CODE_W-1:0] key_code_t;
  typedef logic [NUM_KEYS-1:0]   key_mask_t;

  function automatic logic [2:0] row_drive(
    input logic [1:0] idx
  );
    logic [2:0] r;
    r = ROW0_ACTIVE;
    unique case (1'b1)
      (idx == 2'd1): r = ROW1_ACTIVE;
      (idx == 2'd2): r = ROW2_ACTIVE;
      default:       r = ROW0_ACTIVE;
    endcase
    return r;
  endfunction

  function automatic key_code_t lowest_key(
    input key_mask_t m
  );
    key_code_t r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (m[i]) r = key_code_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// Bundle between board key matrix, scanner and game logic.
// master: scanner side; slave: board/game side.
interface key_matrix_scan_if;
  import wam_pkg::*;

  logic [2:0] key_matrix_column;
  logic [2:0] key_matrix_row;
  key_mask_t  key_state;
  logic       key_press;
  key_code_t  key_code;

  modport master (
    input  key_matrix_column,
    output key_matrix_row,
    output key_state,
    output key_press,
    output key_code
  );

  modport slave (
    output key_matrix_column,
    input  key_matrix_row,
    input  key_state,
    input  key_press,
    input  key_code
  );

endinterface

// File: rtl/key_matrix_scan_debounce.sv
// Per-key debouncer: flips state after DEBOUNCE_SCANS differing samples.
// Ports: clk, reset, sample_en (sample strobe), sample (raw), state.
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic sample,
  output logic state
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (sample_en) begin
      if (sample == state) begin
        cnt <= '0;
      end else if (cnt + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// 3x3 key matrix scanner: row drive, column sync, debounce, press events.
// Ports: CLOCK_50, reset, kbd (matrix lines, key_state, key_press, key_code).
module key_matrix_scan
  import wam_pkg::*;
#(
  parameter int ROW_SETTLE_CYCLES = ROW_SETTLE_CYCLES_DEF,
  parameter int DEBOUNCE_SCANS    = DEBOUNCE_SCANS_DEF
) (
  input logic              CLOCK_50,
  input logic              reset,
  key_matrix_scan_if.master kbd
);

  localparam int CNT_W = $clog2(ROW_SETTLE_CYCLES);

  logic [CNT_W-1:0] settle_cnt;
  logic [1:0]       row_idx;
  logic [1:0]       row_nxt;
  logic [2:0]       row_q;
  logic [2:0]       col_s1;
  logic [2:0]       col_s2;
  logic [2:0]       raw;
  logic             sample;

  key_mask_t state;
  key_mask_t state_d;
  key_mask_t rise;
  key_mask_t pending;
  key_mask_t clr;
  key_mask_t pend_nxt;
  logic      press_q;
  key_code_t code_q;

  assign sample  = settle_cnt == CNT_W'(ROW_SETTLE_CYCLES - 1);
  assign row_nxt = (row_idx == 2'd2) ? 2'd0 : row_idx + 2'd1;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      settle_cnt <= '0;
      row_idx    <= 2'd0;
      row_q      <= ROW0_ACTIVE;
    end else if (sample) begin
      settle_cnt <= '0;
      row_idx    <= row_nxt;
      row_q      <= row_drive(row_nxt);
    end else begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      col_s1 <= 3'b111;
      col_s2 <= 3'b111;
    end else begin
      col_s1 <= kbd.key_matrix_column;
      col_s2 <= col_s1;
    end
  end

  assign raw = ~col_s2;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
      .clk      (CLOCK_50),
      .reset    (reset),
      .sample_en(sample && row_idx == 2'(i / NUM_COLS)),
      .sample   (raw[i % NUM_COLS]),
      .state    (state[i])
    );
  end

  // Lowest pending bit is served each cycle; a fresh rise beats its clear.
  assign rise     = state & ~state_d;
  assign clr      = pending & (~pending + 1'b1);
  assign pend_nxt = (pending & ~clr) | rise;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_d <= '0;
      pending <= '0;
      press_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_d <= state;
      pending <= pend_nxt;
      press_q <= |pending;
      if (|pending) code_q <= lowest_key(pending);
    end
  end

  assign kbd.key_matrix_row = row_q;
  assign kbd.key_state      = state;
  assign kbd.key_press      = press_q;
  assign kbd.key_code       = code_q;

endmodule
